// File: rtl/mem_stage_pkg.sv
// Shared types and default data-memory geometry for the memory-access stage,
// its address checker, the memory model and the bench.
package mem_stage_pkg;

  typedef enum logic [0:0] {
    IDLE,
    ACCESS
  } state_e;

  localparam int unsigned DATA_BASE  = 1024;
  localparam int unsigned DATA_BYTES = 64;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational legality decode for a load/store: conflicting direction,
// misaligned word, or a word that does not lie fully inside the data window.
module mem_addr_check
  import mem_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DATA_BASE,
  parameter int unsigned DEPTH_BYTES = DATA_BYTES
) (
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  output logic        o_fault
);

  // 33-bit limits so BASE_ADDR + DEPTH_BYTES cannot wrap and accept a low address.
  localparam logic [32:0] LoLim = 33'(BASE_ADDR);
  localparam logic [32:0] HiLim = 33'(BASE_ADDR) + 33'(DEPTH_BYTES) - 33'd4;

  logic [32:0] w_addr;

  assign w_addr  = {1'b0, i_addr};
  assign o_fault = (i_read & i_write) |
                   (i_addr[1:0] != 2'b00) |
                   (w_addr < LoLim) |
                   (w_addr > HiLim);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-access stage: checks each load/store, holds it for a fixed access
// window with the upstream frozen, strobes memory once and registers write-back.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DATA_BASE,
  parameter int unsigned DEPTH_BYTES = DATA_BYTES,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic        i_req_read,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic        i_req_wb_en,
  input  logic [3:0]  i_req_dest,
  output logic        o_freeze,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_en,
  output logic [3:0]  o_wb_dest,
  output logic [31:0] o_wb_data,
  output logic        o_addr_fault
);

  localparam int unsigned     CntW    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt;

  logic            r_rd, r_wr, r_lwb_en;
  logic [31:0]     r_addr, r_wdata;
  logic [3:0]      r_dest;

  logic            r_wb_valid, r_wb_en, r_addr_fault;
  logic [3:0]      r_wb_dest;
  logic [31:0]     r_wb_data;

  logic            w_fault, w_memop, w_accept, w_last;

  mem_addr_check #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_addr_check (
    .i_read (i_req_read),
    .i_write(i_req_write),
    .i_addr (i_req_addr),
    .o_fault(w_fault)
  );

  assign w_memop  = i_req_read | i_req_write;
  assign w_accept = (r_state == IDLE) & i_req_valid & w_memop & ~w_fault;
  assign w_last   = (r_state == ACCESS) & (r_cnt == CntLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = ACCESS;
      ACCESS:  if (w_last)   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Strobes are masked while reset is held so an aborted store never lands.
  always_comb begin
    o_freeze    = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      IDLE: o_freeze = w_accept;
      ACCESS: begin
        o_freeze    = ~w_last;
        o_mem_read  = r_rd & ~i_rst;
        o_mem_write = r_wr & w_last & ~i_rst;
        o_mem_addr  = r_addr;
        o_mem_wdata = r_wdata;
      end
      default: o_freeze = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_lwb_en     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_dest       <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_en      <= 1'b0;
      r_wb_dest    <= '0;
      r_wb_data    <= '0;
      r_addr_fault <= 1'b0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_addr_fault <= 1'b0;
      if (r_state == IDLE) begin
        if (i_req_valid) begin
          if (!w_memop) begin
            r_wb_valid <= 1'b1;
            r_wb_en    <= i_req_wb_en;
            r_wb_dest  <= i_req_dest;
            r_wb_data  <= i_req_addr;
          end else if (w_fault) begin
            r_wb_valid   <= 1'b1;
            r_addr_fault <= 1'b1;
            r_wb_en      <= 1'b0;
            r_wb_dest    <= i_req_dest;
            r_wb_data    <= '0;
          end else begin
            r_rd     <= i_req_read;
            r_wr     <= i_req_write;
            r_lwb_en <= i_req_wb_en;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_dest   <= i_req_dest;
            r_cnt    <= '0;
          end
        end
      end else if (w_last) begin
        r_wb_valid <= 1'b1;
        r_wb_en    <= r_lwb_en & r_rd;
        r_wb_dest  <= r_dest;
        r_wb_data  <= r_rd ? i_mem_rdata : 32'd0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_wb_valid   = r_wb_valid;
  assign o_wb_en      = r_wb_en;
  assign o_wb_dest    = r_wb_dest;
  assign o_wb_data    = r_wb_data;
  assign o_addr_fault = r_addr_fault;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, hand-written corner sequences
// and random instructions checked against a transaction-level model.
module tb_mem_stage_ctrl;
  import mem_stage_pkg::*;

  localparam int BASE  = DATA_BASE;
  localparam int DEPTH = DATA_BYTES;
  localparam int W     = 2;

  typedef struct {
    logic        valid, rd, wr;
    logic [31:0] addr, wdata;
    logic        wb_en;
    logic [3:0]  dest;
  } req_t;

  typedef struct {
    int          cycles, frz, rdc, wrp, stray;
    logic        wbv, wben, flt;
    logic [3:0]  dest;
    logic [31:0] data, wr_addr, wr_data, rd_addr;
  } res_t;

  typedef struct {
    req_t        r;
    int          cyc, frz, rdc, wrp;
    logic        flt, wben;
    logic [3:0]  dest;
    logic [31:0] data;
    logic        chk_wb;
  } vec_t;

  logic        clk = 1'b0, rst, mem_init;
  logic        valid, rd, wr, wb_en_in;
  logic [31:0] addr, wdata;
  logic [3:0]  dest;
  logic        freeze, mem_read, mem_write, wb_valid, wb_en, addr_fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [3:0]  wb_dest;
  logic        freeze1, mem_read1, mem_write1, wb_valid1, wb_en1, addr_fault1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1, wb_data1;
  logic [3:0]  wb_dest1;

  logic [7:0]  tb_mem [0:63];
  logic [31:0] m_off;
  logic [31:0] ref_mem [0:15];
  int          wr_edges = 0;
  int          n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_read(rd), .i_req_write(wr),
    .i_req_addr(addr), .i_req_wdata(wdata), .i_req_wb_en(wb_en_in), .i_req_dest(dest),
    .o_freeze(freeze), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_wb_valid(wb_valid), .o_wb_en(wb_en), .o_wb_dest(wb_dest), .o_wb_data(wb_data),
    .o_addr_fault(addr_fault)
  );

  mem_stage_ctrl #(.BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_read(rd), .i_req_write(wr),
    .i_req_addr(addr), .i_req_wdata(wdata), .i_req_wb_en(wb_en_in), .i_req_dest(dest),
    .o_freeze(freeze1), .o_mem_read(mem_read1), .o_mem_write(mem_write1),
    .o_mem_addr(mem_addr1), .o_mem_wdata(mem_wdata1), .i_mem_rdata(mem_rdata1),
    .o_wb_valid(wb_valid1), .o_wb_en(wb_en1), .o_wb_dest(wb_dest1), .o_wb_data(wb_data1),
    .o_addr_fault(addr_fault1)
  );

  assign mem_rdata1 = mem_read1 ? ~mem_addr1 : 32'd0;

  function automatic logic [7:0] pat_byte(int i);
    return 8'(i * 7 + 3);
  endfunction

  // Byte-addressed data memory seen by the main DUT, little-endian words.
  assign m_off = mem_addr - 32'(BASE);

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= pat_byte(i);
    end else if (mem_write && m_off <= 32'd60) begin
      tb_mem[m_off[5:0]]        <= mem_wdata[7:0];
      tb_mem[m_off[5:0] + 6'd1] <= mem_wdata[15:8];
      tb_mem[m_off[5:0] + 6'd2] <= mem_wdata[23:16];
      tb_mem[m_off[5:0] + 6'd3] <= mem_wdata[31:24];
    end
  end

  always @(posedge clk) if (mem_write) wr_edges <= wr_edges + 1;

  always_comb begin
    mem_rdata = '0;
    if (mem_read && m_off <= 32'd60)
      mem_rdata = {tb_mem[m_off[5:0] + 6'd3], tb_mem[m_off[5:0] + 6'd2],
                   tb_mem[m_off[5:0] + 6'd1], tb_mem[m_off[5:0]]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic req_t mk(logic v, logic r, logic w, logic [31:0] a, logic [31:0] d,
                              logic e, logic [3:0] ds);
    req_t q;
    q.valid = v; q.rd = r; q.wr = w; q.addr = a; q.wdata = d; q.wb_en = e; q.dest = ds;
    return q;
  endfunction

  function automatic vec_t mkv(req_t r, int cyc, int frz, int rdc, int wrp, logic flt,
                               logic wben, logic [3:0] ds, logic [31:0] data, logic chk_wb);
    vec_t v;
    v.r = r; v.cyc = cyc; v.frz = frz; v.rdc = rdc; v.wrp = wrp; v.flt = flt;
    v.wben = wben; v.dest = ds; v.data = data; v.chk_wb = chk_wb;
    return v;
  endfunction

  // Transaction-level reference: legality from the address rules, fixed window
  // length, and a word-granular shadow memory updated by accepted stores.
  function automatic vec_t predict(req_t r);
    vec_t   e;
    longint a = {32'd0, r.addr};
    bit     mem = r.rd || r.wr;
    bit     bad = (r.rd && r.wr) || (a % 4 != 0) || (a < BASE) || (a > BASE + DEPTH - 4);
    bit     acc = r.valid && mem && !bad;
    int     idx = acc ? int'((a - BASE) / 4) : 0;
    e.r      = r;
    e.flt    = r.valid && mem && bad;
    e.cyc    = acc ? W + 1 : 1;
    e.frz    = acc ? W : 0;
    e.rdc    = (acc && r.rd) ? W : 0;
    e.wrp    = (acc && r.wr) ? 1 : 0;
    e.wben   = mem ? (acc && r.rd && r.wb_en) : r.wb_en;
    e.chk_wb = r.valid && !e.flt;
    e.dest   = r.dest;
    e.data   = !mem ? r.addr : (r.rd ? ref_mem[idx] : 32'd0);
    if (acc && r.wr) ref_mem[idx] = r.wdata;
    return e;
  endfunction

  task automatic drive(input req_t r);
    valid = r.valid; rd = r.rd; wr = r.wr; addr = r.addr;
    wdata = r.wdata; wb_en_in = r.wb_en; dest = r.dest;
  endtask

  // Upstream behaviour: hold the instruction until freeze drops, then a bubble.
  task automatic run_instr(input req_t r, output res_t o);
    logic f;
    o = '{default: '0};
    drive(r);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      f = freeze;
      o.cycles++;
      if (freeze) o.frz++;
      if (mem_read) begin o.rdc++; o.rd_addr = mem_addr; end
      if (mem_write) begin o.wrp++; o.wr_addr = mem_addr; o.wr_data = mem_wdata; end
      if (wb_valid || addr_fault) o.stray++;
      @(posedge clk); #1;
      if (!f) break;
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    o.wbv = wb_valid; o.wben = wb_en; o.flt = addr_fault; o.dest = wb_dest; o.data = wb_data;
    @(posedge clk); #1;
  endtask

  task automatic cmp_vec(input string t, input vec_t e, input res_t o);
    chk({t, ".cycles"}, 32'(o.cycles), 32'(e.cyc));
    chk({t, ".freeze_cycles"}, 32'(o.frz), 32'(e.frz));
    chk({t, ".read_cycles"}, 32'(o.rdc), 32'(e.rdc));
    chk({t, ".write_pulses"}, 32'(o.wrp), 32'(e.wrp));
    chk({t, ".early_pulse"}, 32'(o.stray), 32'd0);
    chk({t, ".wb_valid"}, 32'(o.wbv), 32'(e.r.valid));
    chk({t, ".addr_fault"}, 32'(o.flt), 32'(e.flt));
    if (e.r.valid) chk({t, ".wb_en"}, 32'(o.wben), 32'(e.wben));
    if (e.chk_wb) begin
      chk({t, ".wb_dest"}, 32'(o.dest), 32'(e.dest));
      chk({t, ".wb_data"}, o.data, e.data);
    end
    if (e.wrp == 1) begin
      chk({t, ".mem_addr_w"}, o.wr_addr, e.r.addr);
      chk({t, ".mem_wdata"}, o.wr_data, e.r.wdata);
    end
    if (e.rdc > 0) chk({t, ".mem_addr_r"}, o.rd_addr, e.r.addr);
  endtask

  task automatic chk_all_zero(input string t);
    chk({t, ".freeze"}, 32'(freeze), 0);
    chk({t, ".mem_read"}, 32'(mem_read), 0);
    chk({t, ".mem_write"}, 32'(mem_write), 0);
    chk({t, ".mem_addr"}, mem_addr, 0);
    chk({t, ".mem_wdata"}, mem_wdata, 0);
    chk({t, ".wb_valid"}, 32'(wb_valid), 0);
    chk({t, ".wb_en"}, 32'(wb_en), 0);
    chk({t, ".wb_dest"}, 32'(wb_dest), 0);
    chk({t, ".wb_data"}, wb_data, 0);
    chk({t, ".addr_fault"}, 32'(addr_fault), 0);
  endtask

  function automatic req_t rand_req();
    req_t        r;
    int unsigned op  = $urandom_range(0, 9);
    int unsigned cat = $urandom_range(0, 5);
    r.valid = ($urandom_range(0, 7) != 0);
    r.rd    = (op inside {[3:5], 8, 9});
    r.wr    = (op inside {6, 7, 8});
    case (cat)
      0, 1, 2: r.addr = 32'(BASE + 4 * int'($urandom_range(0, 15)));
      3:       r.addr = 32'(BASE + int'($urandom_range(0, 63)));
      4: begin
        case ($urandom_range(0, 5))
          0:       r.addr = 32'(BASE - 4);
          1:       r.addr = 32'(BASE - 1);
          2:       r.addr = 32'(BASE);
          3:       r.addr = 32'(BASE + DEPTH - 4);
          4:       r.addr = 32'(BASE + DEPTH - 3);
          default: r.addr = 32'(BASE + DEPTH);
        endcase
      end
      default: r.addr = $urandom;
    endcase
    r.wdata = $urandom;
    r.wb_en = 1'($urandom_range(0, 1));
    r.dest  = 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[11];
    res_t        o;
    logic        f;
    logic [5:0]  pat;
    int          stage, wp, w0;
    logic [31:0] v;
    req_t        rr;
    vec_t        ee;

    for (int w = 0; w < 16; w++)
      ref_mem[w] = {pat_byte(4 * w + 3), pat_byte(4 * w + 2), pat_byte(4 * w + 1),
                    pat_byte(4 * w)};

    tbl[0]  = mkv(mk(1, 0, 1, 1032, 32'hDEADBEEF, 0, 0), 3, 2, 0, 1, 0, 0, 0, 0, 1);
    tbl[1]  = mkv(mk(1, 1, 0, 1032, 0, 1, 5), 3, 2, 2, 0, 0, 1, 5, 32'hDEADBEEF, 1);
    tbl[2]  = mkv(mk(1, 0, 0, 32'h7, 0, 1, 3), 1, 0, 0, 0, 0, 1, 3, 32'h7, 1);
    tbl[3]  = mkv(mk(1, 1, 0, 1022, 0, 1, 1), 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mkv(mk(1, 0, 1, 1085, 32'h1, 0, 0), 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mkv(mk(1, 1, 0, 1026, 0, 1, 2), 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mkv(mk(1, 1, 1, 1024, 32'h5, 1, 7), 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[7]  = mkv(mk(1, 0, 1, 1084, 32'hCAFEF00D, 0, 0), 3, 2, 0, 1, 0, 0, 0, 0, 1);
    tbl[8]  = mkv(mk(1, 1, 0, 1084, 0, 1, 2), 3, 2, 2, 0, 0, 1, 2, 32'hCAFEF00D, 1);
    tbl[9]  = mkv(mk(0, 1, 0, 1024, 0, 1, 1), 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mkv(mk(1, 1, 0, 1024, 0, 0, 4), 3, 2, 2, 0, 0, 0, 4, 32'h18110A03, 1);

    rst = 1'b1; mem_init = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      void'(predict(tbl[i].r));
      run_instr(tbl[i].r, o);
      cmp_vec($sformatf("vec%0d", i), tbl[i], o);
    end

    // Store immediately followed by a load of the same word.
    v = 32'h5A5AC3C3;
    w0 = wr_edges; pat = '0; stage = 0; wp = 0;
    drive(mk(1, 0, 1, 1024, v, 0, 0));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      f = freeze;
      pat = {pat[4:0], f};
      if (mem_write) wp++;
      @(posedge clk); #1;
      if (!f) begin
        if (stage == 0) drive(mk(1, 1, 0, 1024, 0, 1, 9));
        else drive(mk(0, 0, 0, 0, 0, 0, 0));
        stage++;
      end
    end
    @(negedge clk);
    chk("b2b.freeze_pattern", 32'(pat), 32'b110110);
    chk("b2b.write_pulses", 32'(wp), 1);
    chk("b2b.write_edges", 32'(wr_edges - w0), 1);
    chk("b2b.wb_valid", 32'(wb_valid), 1);
    chk("b2b.wb_en", 32'(wb_en), 1);
    chk("b2b.wb_dest", 32'(wb_dest), 9);
    chk("b2b.wb_data", wb_data, v);
    ref_mem[0] = v;
    @(posedge clk); #1;

    // Reset asserted for two cycles in the middle of a store window.
    drive(mk(1, 0, 1, 1028, 32'h11223344, 0, 6));
    @(posedge clk); #1;
    w0 = wr_edges;
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid.wb_valid_late", 32'(wb_valid), 0);
    chk("rst_mid.write_edges", 32'(wr_edges - w0), 0);
    for (int j = 0; j < 4; j++)
      chk($sformatf("rst_mid.byte%0d", 1028 + j), 32'(tb_mem[4 + j]), 32'(pat_byte(4 + j)));
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      rr = rand_req();
      ee = predict(rr);
      run_instr(rr, o);
      cmp_vec($sformatf("rnd%0d", i), ee, o);
    end

    // Single-cycle access window build.
    repeat (4) begin @(posedge clk); #1; end
    drive(mk(1, 1, 0, 1040, 0, 1, 6));
    @(negedge clk);
    chk("w1.freeze_c0", 32'(freeze1), 1);
    chk("w1.mem_read_c0", 32'(mem_read1), 0);
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("w1.freeze_c1", 32'(freeze1), 0);
    chk("w1.mem_read_c1", 32'(mem_read1), 1);
    chk("w1.wb_valid_c1", 32'(wb_valid1), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w1.mem_read_c2", 32'(mem_read1), 0);
    chk("w1.wb_valid_c2", 32'(wb_valid1), 1);
    chk("w1.wb_en", 32'(wb_en1), 1);
    chk("w1.wb_dest", 32'(wb_dest1), 6);
    chk("w1.wb_data", wb_data1, ~32'd1040);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w1.wb_valid_c3", 32'(wb_valid1), 0);
    repeat (4) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-access pipeline stage controller between the EXE/MEM pipeline register and the byte-addressed data memory (clk, MemRead, MemWrite, 32-bit address/WriteData/ReadData).
- Range- and alignment-checks each load/store, holds it for a fixed multi-cycle access window while freezing the upstream pipeline, issues exactly one memory strobe, and registers the result toward write-back.
- Non-memory ops pass through with one-cycle latency.

Parameters:
- BASE_ADDR, 1024, first valid data byte address.
- DEPTH_BYTES, 64, data memory size in bytes.
- WAIT_CYCLES, 2, ACCESS cycles per load/store; must be at least 1.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  EXE/MEM register holds a live instruction
- req_read  in  1  load (LDR)
- req_write  in  1  store (STR)
- req_addr  in  32  ALU result; memory address for loads/stores, result for other ops
- req_wdata  in  32  store data
- req_wb_en  in  1  instruction writes a register
- req_dest  in  4  destination register
- freeze  out  1  hold upstream stages and the EXE/MEM register
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  32  to memory address, full byte address (memory subtracts base)
- mem_wdata  out  32  to memory WriteData
- mem_rdata  in  32  from memory ReadData (combinational)
- wb_valid  out  1  registered one-cycle pulse, result ready
- wb_en  out  1  registered, write-back enable
- wb_dest  out  4  registered
- wb_data  out  32  registered, load data or pass-through result
- addr_fault  out  1  registered one-cycle pulse, rejected access

Behaviour:
- States: IDLE, ACCESS. Counter cnt, width clog2(WAIT_CYCLES)+1.
- Reset (rst=1 at posedge):
  - state=IDLE, cnt=0, latched request cleared.
  - wb_valid=0, wb_en=0, wb_dest=0, wb_data=0, addr_fault=0.
  - Combinational outputs then read 0 (freeze, mem_read, mem_write, mem_addr, mem_wdata).
- Memop: req_read or req_write.
- Fault, evaluated in IDLE:
  - req_read and req_write both set; or
  - req_addr[1:0]!=0; or
  - req_addr < BASE_ADDR; or
  - req_addr > BASE_ADDR+DEPTH_BYTES-4.
  - Unsigned 32-bit compare; no wrap-around acceptance.
- IDLE, no req_valid: nothing; wb_valid=0 next cycle.
- IDLE, req_valid, not memop: next cycle wb_valid=1, wb_en=req_wb_en, wb_dest=req_dest, wb_data=req_addr. freeze=0.
- IDLE, req_valid, memop, fault:
  - No memory strobe, freeze=0.
  - Next cycle: addr_fault=1, wb_valid=1, wb_en=0.
- IDLE, req_valid, memop, no fault:
  - freeze=1 combinationally this cycle.
  - Latch read/write/addr/wdata/wb_en/dest. cnt<=0, state<=ACCESS.
- ACCESS:
  - mem_addr and mem_wdata come from the latch. mem_read=latched read throughout.
  - mem_write=1 only when cnt==WAIT_CYCLES-1, so exactly one write edge per store.
  - freeze=1 while cnt<WAIT_CYCLES-1; freeze=0 on the final cycle so upstream advances on that edge.
  - Final cycle: wb_data<=mem_rdata for loads or 0 for stores; wb_en<=latched wb_en and read; wb_dest<=latched dest; wb_valid<=1; state<=IDLE.
  - Inputs are ignored during ACCESS; the new request is sampled in the following IDLE cycle.
- Latency:
  - Load/store occupies WAIT_CYCLES+1 cycles; wb_valid pulses WAIT_CYCLES+1 cycles after acceptance.
  - Non-memory ops and faults: 1 cycle.
- Back-to-back memops: one idle-evaluation cycle between windows, with freeze asserted in it.
- Reset mid-ACCESS: abort. No mem_write edge occurs after the reset edge, and no wb_valid is produced for the aborted op.
- wb_valid and addr_fault are single-cycle pulses, never held.

Decomposition:
- Shared package mem_stage_pkg holds:
  - state enum {IDLE, ACCESS};
  - default constants DATA_BASE=1024 and DATA_BYTES=64, shared with the memory model and testbench.
- One natural sub-module, mem_addr_check: combinational fault decode from req_read, req_write, req_addr and the parameters, output fault.

Test Plan:
- Reset: rst high for 2 cycles mid-ACCESS with a store pending -> all outputs 0, no mem_write edge after reset, memory bytes 1028..1031 unchanged.
- Store then load, WAIT_CYCLES=2:
  - STR 0xDEADBEEF to 1032 -> freeze high for 2 cycles, mem_write high exactly 1 cycle.
  - LDR 1032 with dest 5 -> wb_valid 3 cycles after acceptance, wb_data=0xDEADBEEF, wb_en=1, wb_dest=5.
- Pass-through: ADD with result 0x00000007, dest 3 -> next cycle wb_valid=1, wb_data=7, wb_dest=3, freeze never high.
- Faults: LDR at 1022, STR at 1085, LDR at 1026, both read and write at 1024 -> each gives addr_fault pulse, wb_en=0, no mem strobe. LDR 1084 -> accepted, no fault.
- Back-to-back: STR 1024 followed immediately by LDR 1024 -> load returns stored value; freeze pattern 1,1,0,1,1,0; exactly one mem_write pulse.
- WAIT_CYCLES=1 build: LDR 1040 -> freeze high 1 cycle only, mem_read 1 cycle, wb_valid 2 cycles after acceptance.
